// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the data cache.
package dcache_pkg;

    localparam int unsigned LINES      = 32;
    localparam int unsigned BLOCK_BITS = 256;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned IDX_W      = $clog2(LINES);
    localparam int unsigned OFF_W      = $clog2(BLOCK_BITS / 8);
    localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WORDS      = BLOCK_BITS / 32;
    localparam int unsigned WSEL_W     = $clog2(WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StRefill,
        StAlloc
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    // Word select within the line; byte offset bits [1:0] are ignored.
    function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WSEL_W];
    endfunction

    function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                     input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Pipeline-side and memory-side signals of the data cache, grouped in one bundle.
// master = environment (pipeline MEM stage + Data_Memory), slave = cache controller.
interface dcache_if;
    import dcache_pkg::*;

    logic [ADDR_W-1:0]     p1_addr_i;
    logic [31:0]           p1_data_i;
    logic                  p1_MemRead_i;
    logic                  p1_MemWrite_i;
    logic [31:0]           p1_data_o;
    logic                  p1_stall_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [BLOCK_BITS-1:0] mem_data_o;
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [BLOCK_BITS-1:0] mem_data_i;
    logic                  mem_ack_i;

    modport master (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport slave (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage: one asynchronous read port and one synchronous
// write port that either installs a whole line or merges a single word.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [BLOCK_BITS-1:0] rd_line_o,
    input  logic                  line_we_i,
    input  logic [TAG_W-1:0]      line_tag_i,
    input  logic [BLOCK_BITS-1:0] line_data_i,
    input  logic                  word_we_i,
    input  logic [WSEL_W-1:0]     word_sel_i,
    input  logic [31:0]           word_data_i
);

    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;

    assign rd_tag_o   = tag_q[idx_i];
    assign rd_line_o  = data_q[idx_i];
    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];

    // Status bits: reset invalidates everything; a fill is clean, a store marks dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; stale contents are masked by valid.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache. Hits complete in the same
// cycle; a miss stalls the pipeline while the FSM writes back a dirty victim and
// refills the line from Data_Memory over a req/ack handshake.
module dcache_controller
    import dcache_pkg::*;
(
    input logic     clk_i,
    input logic     rst_i,
    dcache_if.slave bus
);

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WSEL_W-1:0]     req_word;
    logic                  req;
    logic                  hit;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [BLOCK_BITS-1:0] rd_line;
    logic                  line_we;
    logic                  word_we;
    state_e                state_q;
    logic [BLOCK_BITS-1:0] fill_q;

    assign req_tag  = addr_tag(bus.p1_addr_i);
    assign req_idx  = addr_idx(bus.p1_addr_i);
    assign req_word = addr_word(bus.p1_addr_i);

    // Hit detection, pipeline-facing outputs and array write strobes.
    always_comb begin
        req             = bus.p1_MemRead_i | bus.p1_MemWrite_i;
        hit             = rd_valid & (rd_tag == req_tag);
        bus.p1_stall_o  = req & ~hit;
        bus.p1_data_o   = (bus.p1_MemRead_i & hit) ? rd_line[{req_word, 5'b0} +: 32] : '0;
        line_we         = (state_q == StAlloc) & ~rst_i;
        // A pending store that missed lands here too, one cycle after ALLOC.
        word_we         = (state_q == StIdle) & bus.p1_MemWrite_i & hit & ~rst_i;
    end

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_line_o   (rd_line),
        .line_we_i   (line_we),
        .line_tag_i  (req_tag),
        .line_data_i (fill_q),
        .word_we_i   (word_we),
        .word_sel_i  (req_word),
        .word_data_i (bus.p1_data_i)
    );

    // Miss FSM with registered memory-side outputs. The request is frozen while
    // stalled, so req_tag/req_idx remain valid for the whole miss sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            bus.mem_enable_o <= 1'b0;
            bus.mem_write_o  <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_data_o   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && !hit) begin
                        bus.mem_enable_o <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q         <= StWriteback;
                            bus.mem_write_o <= 1'b1;
                            bus.mem_addr_o  <= block_addr(rd_tag, req_idx);
                            bus.mem_data_o  <= rd_line;
                        end else begin
                            state_q         <= StRefill;
                            bus.mem_write_o <= 1'b0;
                            bus.mem_addr_o  <= block_addr(req_tag, req_idx);
                        end
                    end
                end
                StWriteback: begin
                    // Enable drops for one cycle before the refill request starts.
                    if (bus.mem_ack_i) begin
                        state_q          <= StRefill;
                        bus.mem_enable_o <= 1'b0;
                        bus.mem_write_o  <= 1'b0;
                        bus.mem_addr_o   <= block_addr(req_tag, req_idx);
                        bus.mem_data_o   <= '0;
                    end
                end
                StRefill: begin
                    if (!bus.mem_enable_o) begin
                        bus.mem_enable_o <= 1'b1;
                    end else if (bus.mem_ack_i) begin
                        state_q          <= StAlloc;
                        bus.mem_enable_o <= 1'b0;
                        bus.mem_addr_o   <= '0;
                        fill_q           <= bus.mem_data_i;
                    end
                end
                StAlloc: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a small Data_Memory model that acks
// after a fixed number of enable cycles.
module tb_dcache_controller;
    import dcache_pkg::*;

    localparam int unsigned AckLat = 3;

    logic clk;
    logic rst;

    dcache_if bus ();

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [BLOCK_BITS-1:0] mem [128];
    int                    n_tests;
    int                    n_fail;
    int                    en_cycles;
    int                    wb_count;
    int                    rf_count;
    logic [ADDR_W-1:0]     last_wb_addr;
    logic [ADDR_W-1:0]     last_rf_addr;
    logic [BLOCK_BITS-1:0] last_wb_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [BLOCK_BITS-1:0] act,
                            input logic [BLOCK_BITS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int blk, input int w);
        return 32'hA000_0000 | (32'(blk) << 8) | 32'(w);
    endfunction

    always @(negedge clk) begin
        assert (!(bus.p1_MemRead_i && bus.p1_MemWrite_i))
            else $error("read and write requested together");
    end

    // Memory model: ack in the AckLat-th cycle of enable, then expect enable to drop.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack_i) begin
                check_eq("en_drop_after_ack", bus.mem_enable_o, 0);
                bus.mem_ack_i  = 1'b0;
                bus.mem_data_i = '0;
                cnt = 0;
            end else if (bus.mem_enable_o) begin
                en_cycles++;
                cnt++;
                if (cnt == AckLat) begin
                    cnt = 0;
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_write_o) begin
                        mem[bus.mem_addr_o[11:5]] = bus.mem_data_o;
                        wb_count++;
                        last_wb_addr = bus.mem_addr_o;
                        last_wb_data = bus.mem_data_o;
                    end else begin
                        bus.mem_data_i = mem[bus.mem_addr_o[11:5]];
                        rf_count++;
                        last_rf_addr = bus.mem_addr_o;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Present one request and hold it until the stall clears; the access retires
    // at the following rising edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int stalls,
                          output logic [31:0] rdata);
        @(negedge clk);
        bus.p1_MemRead_i  = rd;
        bus.p1_MemWrite_i = wr;
        bus.p1_addr_i     = addr;
        bus.p1_data_i     = wdata;
        stalls = 0;
        #1;
        while (bus.p1_stall_o && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (bus.p1_stall_o) check_eq("access_timeout", bus.p1_stall_o, 0);
        rdata = bus.p1_data_o;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        int                    st;
        int                    total;
        int                    en0;
        logic [31:0]           rd;
        logic [BLOCK_BITS-1:0] exp_line;

        n_tests = 0;
        n_fail = 0;
        en_cycles = 0;
        wb_count = 0;
        rf_count = 0;
        last_wb_addr = '0;
        last_rf_addr = '0;
        last_wb_data = '0;
        for (int b = 0; b < 128; b++)
            for (int w = 0; w < 8; w++) mem[b][w*32 +: 32] = pat(b, w);

        rst = 1'b1;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
        bus.p1_addr_i     = '0;
        bus.p1_data_i     = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_stall", bus.p1_stall_o, 0);
        check_eq("rst_enable", bus.mem_enable_o, 0);
        check_eq("rst_write", bus.mem_write_o, 0);
        check_eq("rst_addr", bus.mem_addr_o, 0);
        check_eq("rst_data", bus.p1_data_o, 0);
        check_eq("rst_mem_data", bus.mem_data_o, 0);
        rst = 1'b0;

        // Cold load: clean miss, N+2 stall cycles.
        access(1'b1, 1'b0, 32'h40, 32'h0, st, rd);
        check_eq("cold_stalls", st, AckLat + 2);
        check_eq("cold_data", rd, 32'hA000_0200);
        check_eq("cold_rf_addr", last_rf_addr, 32'h40);
        check_eq("cold_rf_count", rf_count, 1);
        check_eq("cold_wb_count", wb_count, 0);

        // Store hit and read-back, no memory traffic.
        en0 = en_cycles;
        access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, st, rd);
        check_eq("st_hit_stalls", st, 0);
        access(1'b1, 1'b0, 32'h44, 32'h0, st, rd);
        check_eq("st_rb_stalls", st, 0);
        check_eq("st_rb_data", rd, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h48, 32'h0, st, rd);
        check_eq("st_neighbour", rd, 32'hA000_0202);
        check_eq("st_no_mem", en_cycles - en0, 0);

        // Dirty eviction by alias 1 KiB away: 2N+3 stall cycles.
        access(1'b1, 1'b0, 32'h444, 32'h0, st, rd);
        check_eq("dirty_stalls", st, 2 * AckLat + 3);
        check_eq("dirty_wb_count", wb_count, 1);
        check_eq("dirty_wb_addr", last_wb_addr, 32'h40);
        check_eq("dirty_wb_w0", last_wb_data[31:0], 32'hA000_0200);
        check_eq("dirty_wb_w1", last_wb_data[63:32], 32'hDEAD_BEEF);
        check_eq("dirty_rf_addr", last_rf_addr, 32'h440);
        check_eq("dirty_data", rd, 32'hA000_2201);

        // Reload the evicted line: clean miss, memory now holds the stored word.
        access(1'b1, 1'b0, 32'h44, 32'h0, st, rd);
        check_eq("reload_stalls", st, AckLat + 2);
        check_eq("reload_data", rd, 32'hDEAD_BEEF);
        check_eq("reload_wb_count", wb_count, 1);

        // Store miss: allocate, then merge; line becomes dirty.
        access(1'b0, 1'b1, 32'h800, 32'h1234_5678, st, rd);
        check_eq("stmiss_stalls", st, AckLat + 2);
        access(1'b1, 1'b0, 32'h800, 32'h0, st, rd);
        check_eq("stmiss_w0", rd, 32'h1234_5678);
        check_eq("stmiss_w0_stalls", st, 0);
        access(1'b1, 1'b0, 32'h804, 32'h0, st, rd);
        check_eq("stmiss_w1", rd, 32'hA000_4001);
        access(1'b1, 1'b0, 32'h81C, 32'h0, st, rd);
        check_eq("stmiss_w7", rd, 32'hA000_4007);
        access(1'b1, 1'b0, 32'h000, 32'h0, st, rd);
        check_eq("stmiss_evict_stalls", st, 2 * AckLat + 3);
        check_eq("stmiss_evict_addr", last_wb_addr, 32'h800);
        for (int w = 0; w < 8; w++) exp_line[w*32 +: 32] = pat(64, w);
        exp_line[31:0] = 32'h1234_5678;
        check_eq("stmiss_evict_line", last_wb_data, exp_line);
        check_eq("stmiss_evict_data", rd, 32'hA000_0000);

        // Fill all 32 indices, then back-to-back hits with no stalls or traffic.
        for (int i = 0; i < 32; i++) access(1'b1, 1'b0, 32'(i * 32), 32'h0, st, rd);
        en0 = en_cycles;
        total = 0;
        for (int i = 0; i < 32; i++) begin
            access(1'b1, 1'b0, 32'(i * 32 + 4 * (i % 8)), 32'h0, st, rd);
            total += st;
            check_eq("hit32_data", rd, pat(i, i % 8));
        end
        check_eq("hit32_stalls", total, 0);
        check_eq("hit32_no_mem", en_cycles - en0, 0);

        // Reset in the middle of a refill handshake.
        @(negedge clk);
        bus.p1_MemRead_i  = 1'b1;
        bus.p1_MemWrite_i = 1'b0;
        bus.p1_addr_i     = 32'hC40;
        @(negedge clk);
        #1;
        check_eq("midrst_en_before", bus.mem_enable_o, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midrst_enable", bus.mem_enable_o, 0);
        check_eq("midrst_write", bus.mem_write_o, 0);
        check_eq("midrst_addr", bus.mem_addr_o, 0);
        check_eq("midrst_stall_req", bus.p1_stall_o, 1);
        check_eq("midrst_data", bus.p1_data_o, 0);
        rst = 1'b0;
        bus.p1_MemRead_i = 1'b0;
        #1;
        check_eq("midrst_stall_noreq", bus.p1_stall_o, 0);
        access(1'b1, 1'b0, 32'h40, 32'h0, st, rd);
        check_eq("postrst_stalls", st, AckLat + 2);
        check_eq("postrst_rf_addr", last_rf_addr, 32'h40);
        check_eq("postrst_data", rd, 32'hA000_0200);
        go_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
